axi_dma_w_sched: RTL and testbench

Write-side burst scheduler for the AXI4 DMA write path, running in the "clk" domain.
- Accepts burst commands (awlen) from the DMA address generator and gates them onto the AXI AW channel under an outstanding-transaction credit limit of OD.
- Queues each accepted burst length and frames the user write-data stream into AXI W beats, generating wlast.
- Retires bursts on B responses and reports idle/error status to the DMA control logic.

---
 rtl/axi_dma_w_sched.sv | 192 +++++++++++++++++++
 tb/tb_axi_dma_w_sched.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_w_sched.sv
// axi_dma_w_sched: write-side burst scheduler for the AXI4 DMA write path.
// Gates burst commands onto AW under an outstanding-burst credit limit (OD).
// Queues accepted burst lengths and frames the user stream into W beats with wlast.
// Retires bursts on B responses.
// Optional: define AXI_DMA_W_SCHED_WBUF_EN to insert a 2-entry registered skid
// buffer between the user stream and the W channel.
module axi_dma_w_sched #(
  parameter int AXI_DW     = 128,
  parameter int AXI_IW     = 12,
  parameter int AXI_LW     = 8,
  parameter int AXI_WSTRBW = 16,
  parameter int AXI_BRESPW = 2,
  parameter int OD         = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  input  logic [AXI_LW-1:0]         cmd_len,
  output logic                      cmd_ready,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [AXI_DW-1:0]         axi_wdata,
  output logic [AXI_WSTRBW-1:0]     axi_wstrb,
  output logic                      axi_wlast,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  input  logic [AXI_IW-1:0]         axi_bid,
  input  logic [AXI_BRESPW-1:0]     axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  input  logic                      usr_wvalid,
  input  logic [AXI_DW-1:0]         usr_wdata,
  output logic                      usr_wready,
  output logic [$clog2(OD):0]       outstanding,
  output logic                      idle,
  output logic                      err,
  input  logic                      err_clr
);

  localparam int PW = $clog2(OD);
  localparam int CW = PW + 1;

  logic [CW-1:0]     out_cnt_reg;
  logic [CW-1:0]     fifo_cnt_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [AXI_LW-1:0] len_mem [OD];
  logic [AXI_LW-1:0] beat_cnt_reg;
  logic              err_reg;

  logic              credit_ok;
  logic              aw_fire;
  logic              b_fire;
  logic              fifo_ne;
  logic [AXI_LW-1:0] fifo_head;
  logic              in_fire;   // a beat enters the framing logic
  logic              in_last;   // that beat closes the head burst
  logic              fifo_pop;
  logic              buf_empty;

  // B id is not checked: responses are counted, not matched to bursts.
  logic unused_bid;
  assign unused_bid = ^axi_bid;

  // AW gating under credit; both handshake outputs are combinational.
  assign credit_ok   = (out_cnt_reg < CW'(OD));
  assign axi_awvalid = cmd_valid & credit_ok;
  assign cmd_ready   = axi_awready & credit_ok;
  assign aw_fire     = cmd_valid & cmd_ready;

  assign axi_bready  = (out_cnt_reg != '0);
  assign b_fire      = axi_bvalid & axi_bready;

  assign fifo_ne     = (fifo_cnt_reg != '0);
  assign fifo_head   = len_mem[rd_ptr_reg];
  assign fifo_pop    = in_fire & in_last;

  genvar gi;
  generate
    for (gi = 0; gi < AXI_WSTRBW; gi++) begin : g_strb
      assign axi_wstrb[gi] = 1'b1;
    end
  endgenerate

`ifdef AXI_DMA_W_SCHED_WBUF_EN
  logic [1:0]        buf_cnt_reg;
  logic [AXI_DW-1:0] buf_data_reg [2];
  logic              buf_last_reg [2];
  logic              out_fire;
  logic [1:0]        buf_wr_idx;

  // Accept user data only while a burst is queued and the buffer has room.
  assign usr_wready  = fifo_ne & (buf_cnt_reg != 2'd2);
  assign in_fire     = usr_wvalid & usr_wready;
  assign in_last     = (beat_cnt_reg == fifo_head);
  assign axi_wvalid  = (buf_cnt_reg != 2'd0);
  assign axi_wdata   = buf_data_reg[0];
  assign axi_wlast   = buf_last_reg[0];
  assign out_fire    = axi_wvalid & axi_wready;
  assign buf_wr_idx  = buf_cnt_reg - {1'b0, out_fire};
  assign buf_empty   = (buf_cnt_reg == 2'd0);

  // Skid buffer: entry 0 drives W; shift on output, append at the free slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_cnt_reg     <= 2'd0;
      buf_data_reg[0] <= '0;
      buf_data_reg[1] <= '0;
      buf_last_reg[0] <= 1'b0;
      buf_last_reg[1] <= 1'b0;
    end else begin
      if (out_fire) begin
        buf_data_reg[0] <= buf_data_reg[1];
        buf_last_reg[0] <= buf_last_reg[1];
      end
      if (in_fire) begin
        buf_data_reg[buf_wr_idx[0]] <= usr_wdata;
        buf_last_reg[buf_wr_idx[0]] <= in_last;
      end
      buf_cnt_reg <= buf_cnt_reg + {1'b0, in_fire} - {1'b0, out_fire};
    end
  end
`else
  // Combinational pass-through; W only runs while a burst length is queued.
  assign axi_wvalid  = usr_wvalid & fifo_ne;
  assign usr_wready  = axi_wready & fifo_ne;
  assign axi_wdata   = usr_wdata;
  assign axi_wlast   = fifo_ne & (beat_cnt_reg == fifo_head);
  assign in_fire     = axi_wvalid & axi_wready;
  assign in_last     = axi_wlast;
  assign buf_empty   = 1'b1;
`endif

  // Length FIFO storage; no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (aw_fire) begin
      len_mem[wr_ptr_reg] <= cmd_len;
    end
  end

  // Length FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (aw_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      fifo_cnt_reg <= fifo_cnt_reg + {{(CW-1){1'b0}}, aw_fire}
                                   - {{(CW-1){1'b0}}, fifo_pop};
    end
  end

  // Beat counter within the head burst; wraps to zero on the last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_reg <= '0;
    end else if (in_fire) begin
      beat_cnt_reg <= in_last ? '0 : beat_cnt_reg + 1'b1;
    end
  end

  // Outstanding-burst credit counter: issue adds, response retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_reg <= '0;
    end else begin
      case ({aw_fire, b_fire})
        2'b10:   out_cnt_reg <= out_cnt_reg + 1'b1;
        2'b01:   out_cnt_reg <= out_cnt_reg - 1'b1;
        default: out_cnt_reg <= out_cnt_reg;
      endcase
    end
  end

  // Sticky error flag; a new error response beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else if (b_fire && (axi_bresp != '0)) begin
      err_reg <= 1'b1;
    end else if (err_clr) begin
      err_reg <= 1'b0;
    end
  end

  assign outstanding = out_cnt_reg;
  assign err         = err_reg;
  assign idle        = (out_cnt_reg == '0) & ~fifo_ne & buf_empty;

endmodule

// File: tb/tb_axi_dma_w_sched.sv
// tb_axi_dma_w_sched: scoreboard bench for axi_dma_w_sched.
// Inputs are driven 1 time unit after posedge; everything is sampled on negedge.
module tb_axi_dma_w_sched;

  localparam int DW = 128;
  localparam int IW = 12;
  localparam int LW = 8;
  localparam int SW = 16;
  localparam int RW = 2;
  localparam int OD = 4;

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic [LW-1:0] cmd_len;
  logic          cmd_ready;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_wlast;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [IW-1:0] axi_bid;
  logic [RW-1:0] axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready;
  logic          usr_wvalid;
  logic [DW-1:0] usr_wdata;
  logic          usr_wready;
  logic [2:0]    outstanding;
  logic          idle;
  logic          err;
  logic          err_clr;

  axi_dma_w_sched #(
    .AXI_DW(DW), .AXI_IW(IW), .AXI_LW(LW), .AXI_WSTRBW(SW), .AXI_BRESPW(RW), .OD(OD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready),
    .usr_wvalid(usr_wvalid), .usr_wdata(usr_wdata), .usr_wready(usr_wready),
    .outstanding(outstanding), .idle(idle), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [LW-1:0] len_q[$];
  int            mbeat;
  int            model_out;
  int            aw_cnt;
  int            w_cnt;
  int            wlast_cnt;
  int            n_chk;
  int            n_fail;
  bit            usr_en;
  bit            bp_en;
  bit            usr_took;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  // Transaction monitor and scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      usr_took = usr_wvalid && usr_wready;
      if (usr_took) begin
        if (len_q.size() == 0) begin
          check_val("w_lead", usr_wready, 1'b0);
        end else begin
          exp_t e;
          e.data = usr_wdata;
          e.last = (mbeat == int'(len_q[0]));
          exp_q.push_back(e);
          if (e.last) begin
            void'(len_q.pop_front());
            mbeat = 0;
          end else begin
            mbeat++;
          end
        end
      end
      if (axi_wvalid && axi_wready) begin
        w_cnt++;
        if (axi_wlast) wlast_cnt++;
        $display("W  beat=%0d last=%0b data=%h", w_cnt, axi_wlast, axi_wdata);
        if (exp_q.size() == 0) begin
          check_val("w_extra", axi_wvalid, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("wdata", axi_wdata, e.data);
          check_val("wlast", axi_wlast, e.last);
          check_val("wstrb", axi_wstrb, {SW{1'b1}});
        end
      end
      if (cmd_valid && cmd_ready) begin
        len_q.push_back(cmd_len);
        aw_cnt++;
        model_out++;
        $display("AW len=%0d outstanding_before=%0d", cmd_len, outstanding);
      end
      if (axi_bvalid && axi_bready) begin
        model_out--;
        $display("B  resp=%0d outstanding_before=%0d", axi_bresp, outstanding);
      end
    end else begin
      usr_took = 1'b0;
    end
  end

  // User stream source: valid is held until taken unless the stream is disabled.
  initial begin
    usr_wvalid = 1'b0;
    usr_wdata  = {$urandom, $urandom, $urandom, $urandom};
    axi_wready = 1'b1;
    forever begin
      drv();
      if (!usr_en) begin
        usr_wvalid = 1'b0;
      end else if (!usr_wvalid || usr_took) begin
        if (usr_took) usr_wdata = {$urandom, $urandom, $urandom, $urandom};
        usr_wvalid = !bp_en || ($urandom_range(0, 3) != 0);
      end
      axi_wready = !bp_en || ($urandom_range(0, 2) != 0);
    end
  end

  task automatic issue_cmd(input logic [LW-1:0] len);
    int n = 0;
    drv();
    cmd_valid = 1'b1;
    cmd_len   = len;
    samp();
    while (!cmd_ready && n < 200) begin
      samp();
      n++;
    end
    if (n >= 200) check_val("aw_timeout", cmd_ready, 1'b1);
    drv();
    cmd_valid = 1'b0;
  endtask

  task automatic send_b(input logic [RW-1:0] r, input logic c);
    int n = 0;
    drv();
    axi_bvalid = 1'b1;
    axi_bresp  = r;
    err_clr    = c;
    samp();
    while (!axi_bready && n < 50) begin
      samp();
      n++;
    end
    if (n >= 50) check_val("b_timeout", axi_bready, 1'b1);
    drv();
    axi_bvalid = 1'b0;
    axi_bresp  = '0;
    err_clr    = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((len_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      samp();
      n++;
    end
    if (n >= budget) check_val("drain_timeout", len_q.size() + exp_q.size(), 0);
    samp();
  endtask

  task automatic retire_all();
    int guard = 0;
    while (model_out > 0 && guard < 20) begin
      send_b('0, 1'b0);
      guard++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int w0;
    int l0;
    int n;
    n_chk = 0; n_fail = 0; aw_cnt = 0; w_cnt = 0; wlast_cnt = 0;
    mbeat = 0; model_out = 0; usr_en = 1'b0; bp_en = 1'b0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; axi_awready = 1'b1;
    axi_bid = '0; axi_bresp = '0; axi_bvalid = 1'b0; err_clr = 1'b0;

    // Reset state
    repeat (3) samp();
    check_val("rst_outstanding", outstanding, 0);
    check_val("rst_idle", idle, 1'b1);
    check_val("rst_err", err, 1'b0);
    check_val("rst_awvalid", axi_awvalid, 1'b0);
    check_val("rst_wvalid", axi_wvalid, 1'b0);
    check_val("rst_bready", axi_bready, 1'b0);
    check_val("rst_usr_wready", usr_wready, 1'b0);
    drv();
    reset_n = 1'b1;
    usr_en  = 1'b1;

    // 1: single 4-beat burst
    w0 = w_cnt; l0 = wlast_cnt;
    issue_cmd(8'd3);
    wait_drain(200);
    check_val("t1_beats", w_cnt - w0, 4);
    check_val("t1_wlast", wlast_cnt - l0, 1);
    check_val("t1_outstanding", outstanding, 1);
    check_val("t1_busy", idle, 1'b0);
    send_b(2'b00, 1'b0);
    samp();
    check_val("t1_out_after_b", outstanding, 0);
    check_val("t1_idle", idle, 1'b1);
    check_val("t1_err", err, 1'b0);

    // 2: credit limit
    a0 = aw_cnt;
    drv();
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    repeat (8) samp();
    check_val("t2_aw4", aw_cnt - a0, 4);
    check_val("t2_awvalid_blocked", axi_awvalid, 1'b0);
    check_val("t2_cmd_ready_blocked", cmd_ready, 1'b0);
    check_val("t2_outstanding", outstanding, OD);
    drv();
    axi_bvalid = 1'b1;
    axi_bresp  = 2'b00;
    samp();
    check_val("t2_bready", axi_bready, 1'b1);
    check_val("t2_no_aw_with_b", cmd_ready, 1'b0);
    drv();
    axi_bvalid = 1'b0;
    samp();
    check_val("t2_awvalid5", axi_awvalid, 1'b1);
    check_val("t2_cmd_ready5", cmd_ready, 1'b1);
    drv();
    cmd_valid = 1'b0;
    samp();
    check_val("t2_aw5", aw_cnt - a0, 5);
    wait_drain(200);
    retire_all();
    samp();
    check_val("t2_idle", idle, 1'b1);

    // 3: mixed lengths with random backpressure
    w0 = w_cnt; l0 = wlast_cnt;
    bp_en = 1'b1;
    issue_cmd(8'd0);
    issue_cmd(8'd15);
    issue_cmd(8'd7);
    wait_drain(2000);
    bp_en = 1'b0;
    samp();
    samp();
    check_val("t3_beats", w_cnt - w0, 25);
    check_val("t3_wlast", wlast_cnt - l0, 3);
    check_val("t3_fifo_empty", usr_wready, 1'b0);
    retire_all();
    samp();
    check_val("t3_idle", idle, 1'b1);

    // 4a: aw_fire and b_fire together at outstanding=2
    usr_en = 1'b0;
    samp();
    samp();
    issue_cmd(8'd1);
    issue_cmd(8'd0);
    samp();
    check_val("t4_out2", outstanding, 2);
    drv();
    cmd_valid = 1'b1;
    cmd_len   = 8'd2;
    axi_bvalid = 1'b1;
    axi_bresp  = 2'b00;
    samp();
    check_val("t4_aw_same", cmd_ready, 1'b1);
    check_val("t4_b_same", axi_bready, 1'b1);
    drv();
    cmd_valid  = 1'b0;
    axi_bvalid = 1'b0;
    samp();
    check_val("t4_out_held", outstanding, 2);
    w0 = w_cnt; l0 = wlast_cnt;
    usr_en = 1'b1;
    wait_drain(200);
    check_val("t4_beats", w_cnt - w0, 6);
    check_val("t4_wlast", wlast_cnt - l0, 3);

    // 4b: continuous push-while-pop with single-beat bursts, then a 4-beat burst
    a0 = aw_cnt;
    drv();
    cmd_valid  = 1'b1;
    cmd_len    = 8'd0;
    axi_bvalid = 1'b1;
    axi_bresp  = 2'b00;
    repeat (6) samp();
    drv();
    cmd_valid  = 1'b0;
    axi_bvalid = 1'b0;
    wait_drain(200);
    check_val("t4_pushpop_aw", aw_cnt - a0, 6);
    w0 = w_cnt; l0 = wlast_cnt;
    issue_cmd(8'd3);
    wait_drain(200);
    check_val("t4_next_beats", w_cnt - w0, 4);
    check_val("t4_next_wlast", wlast_cnt - l0, 1);
    retire_all();
    samp();
    check_val("t4_idle", idle, 1'b1);

    // 5: sticky error
    check_val("t5_err_start", err, 1'b0);
    issue_cmd(8'd0);
    wait_drain(200);
    send_b(2'b10, 1'b0);
    samp();
    check_val("t5_err_set", err, 1'b1);
    issue_cmd(8'd0);
    wait_drain(200);
    send_b(2'b00, 1'b0);
    samp();
    check_val("t5_err_sticky", err, 1'b1);
    issue_cmd(8'd0);
    wait_drain(200);
    send_b(2'b10, 1'b1);
    samp();
    check_val("t5_set_beats_clr", err, 1'b1);
    drv();
    err_clr = 1'b1;
    drv();
    err_clr = 1'b0;
    samp();
    check_val("t5_err_cleared", err, 1'b0);

    // 6: reset in the middle of an 8-beat burst
    usr_en = 1'b0;
    samp();
    samp();
    issue_cmd(8'd7);
    w0 = w_cnt;
    usr_en = 1'b1;
    n = 0;
    while ((w_cnt - w0) < 2 && n < 100) begin
      samp();
      n++;
    end
    if (n >= 100) check_val("t6_timeout", w_cnt - w0, 2);
    drv();
    reset_n   = 1'b0;
    usr_en    = 1'b0;
    cmd_valid = 1'b0;
    #1;
    len_q.delete();
    exp_q.delete();
    mbeat     = 0;
    model_out = 0;
    check_val("t6_outstanding", outstanding, 0);
    check_val("t6_awvalid", axi_awvalid, 1'b0);
    check_val("t6_wvalid", axi_wvalid, 1'b0);
    check_val("t6_bready", axi_bready, 1'b0);
    check_val("t6_usr_wready", usr_wready, 1'b0);
    samp();
    drv();
    reset_n = 1'b1;
    samp();
    check_val("t6_idle", idle, 1'b1);
    check_val("t6_out_after", outstanding, 0);
    usr_en = 1'b1;
    w0 = w_cnt;
    issue_cmd(8'd1);
    wait_drain(200);
    check_val("t6_post_beats", w_cnt - w0, 2);
    retire_all();
    samp();
    check_val("t6_post_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
